// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose:
//   RAW hazard scoreboard for the pipelined core. It generalises the old
//   single load-use detector. Each architectural register has a small
//   countdown. The countdown holds the number of cycles left before that
//   register's in-flight result can be forwarded. While the instruction in ID
//   reads a register whose countdown is non-zero, the front end stalls and a
//   bubble goes into ID/EX.
//
// Parameters:
//   NREG    - architectural register count (register 0 is hard-wired zero)
//   RAW     - register index width, clog2(NREG)
//   MAX_LAT - largest producer latency tracked, in stall cycles
//   CW      - countdown width, clog2(MAX_LAT+1)
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   id_valid                 - ID holds a real instruction
//   id_rs1/id_rs2            - source register indices
//   id_rs1_used/id_rs2_used  - the instruction actually reads that source
//   id_rd, id_regwrite       - destination index and its write enable
//   id_lat                   - stall cycles a consumer of rd must wait
//   flush                    - squash the ID instruction this cycle
//   pc_write, if_id_write    - front-end advance enables (low = stall)
//   ctrl_bubble              - zero the control word going into ID/EX
//   stall_src                - bit0: rs1 caused the stall, bit1: rs2 did
//   pending                  - bit r set while register r's countdown is non-zero
//
// Optional feature (macro HAZARD_SCOREBOARD_STATS_EN):
//   When defined, the outputs stall_cycles[31:0] and stall_events[31:0] are
//   added. They count stalled cycles and stall onsets. Both wrap and clear
//   on rst.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int RAW     = 5,
    parameter int MAX_LAT = 4,
    parameter int CW      = $clog2(MAX_LAT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RAW-1:0]  id_rs1,
    input  logic [RAW-1:0]  id_rs2,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [RAW-1:0]  id_rd,
    input  logic            id_regwrite,
    input  logic [CW-1:0]   id_lat,
    input  logic            flush,
    output logic            pc_write,
    output logic            if_id_write,
    output logic            ctrl_bubble,
    output logic [1:0]      stall_src,
    output logic [NREG-1:0] pending
`ifdef HAZARD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     stall_events
`endif
);

    logic [CW-1:0] cnt_q   [NREG];
    logic [CW-1:0] cnt_d   [NREG];
    logic [CW-1:0] cnt_dec [NREG];

    logic          haz1;
    logic          haz2;
    logic          stall;
    logic          issue;
    logic [CW-1:0] lat_s;

    // Hazard detection. Register 0 is never a real dependency, even if a
    // stray countdown were present. A flush overrides the stall because the
    // squashed instruction does not need its operands.
    always_comb begin
        haz1  = id_valid & id_rs1_used & (id_rs1 != '0) & (cnt_q[id_rs1] != '0);
        haz2  = id_valid & id_rs2_used & (id_rs2 != '0) & (cnt_q[id_rs2] != '0);
        stall = (haz1 | haz2) & ~flush;
        issue = id_valid & ~stall & ~flush & id_regwrite & (id_rd != '0);
        // id_lat can encode values above MAX_LAT, so clamp it to the tracked maximum.
        lat_s = (id_lat > CW'(MAX_LAT)) ? CW'(MAX_LAT) : id_lat;
    end

    always_comb begin
        pc_write    = ~stall;
        if_id_write = ~stall;
        ctrl_bubble = stall | flush;
        stall_src   = {haz2, haz1} & {2{~flush}};
    end

    // Every countdown saturates at zero. An issue into a register that is
    // still pending takes the larger of the remaining and the new latency.
    // A WAW reissue therefore never makes a consumer wait less than the
    // older producer requires.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_dec[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
            if (issue && (id_rd == RAW'(r))) begin
                cnt_d[r] = (cnt_dec[r] > lat_s) ? cnt_dec[r] : lat_s;
            end else begin
                cnt_d[r] = cnt_dec[r];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pending[r] = (cnt_q[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;
    logic [31:0] stall_events_q;
    logic [31:0] stall_events_d;
    logic        stall_prev_q;
    logic        stall_prev_d;

    // An event is a 0->1 transition of stall. The previous stall value is
    // registered so that a multi-cycle stall counts as one event.
    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, stall};
        stall_events_d = stall_events_q + {31'd0, (stall & ~stall_prev_q)};
        stall_prev_d   = stall;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            stall_events_q <= '0;
            stall_prev_q   <= 1'b0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            stall_events_q <= stall_events_d;
            stall_prev_q   <= stall_prev_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign stall_events = stall_events_q;
`endif

endmodule
